// File: rtl/writeback_queue.sv
// Writeback queue: 4-entry in-order FIFO that merges ALU and load results onto one register-file write port.
// Define WB_FORWARD_EN to forward the youngest matching queued result onto the operand read path.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Alu_valid,
  input  logic [2:0]  Alu_wreg,
  input  logic [15:0] Alu_data,
  output logic        Alu_ready,
  input  logic        Mem_valid,
  input  logic [2:0]  Mem_wreg,
  input  logic [15:0] Mem_data,
  output logic        Mem_ready,
  output logic        Write_enable,
  output logic [2:0]  Wreg,
  output logic [15:0] Data_in,
  output logic [7:0]  Busy,
  output logic [2:0]  Level,
  input  logic [2:0]  Rreg1,
  input  logic [2:0]  Rreg2,
  input  logic [15:0] Rf_R1,
  input  logic [15:0] Rf_R2,
  output logic [15:0] Fwd_R1,
  output logic [15:0] Fwd_R2
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [2:0]       wreg_q [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] alu_slot;
  logic [2:0]       count;
  logic [2:0]       count_next;
  logic             mem_push;
  logic             alu_push;
  logic             pop;

  // Handshakes: ALU yields the last free slot to a pending load so loads never stall behind ALU results.
  always_comb begin
    Mem_ready  = (count <= 3'd3);
    Alu_ready  = (count <= 3'd2) || ((count == 3'd3) && !Mem_valid);
    mem_push   = Mem_valid && Mem_ready;
    alu_push   = Alu_valid && Alu_ready;
    pop        = (count != 3'd0);
    alu_slot   = mem_push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    count_next = count + {2'b00, mem_push} + {2'b00, alu_push} - {2'b00, pop};
  end

  // Pointer and occupancy state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= 3'd0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop);
      wr_ptr <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
      count  <= count_next;
    end
  end

  // Entry storage is never reset; stale slots are masked by count everywhere they are read.
  always_ff @(posedge Clock) begin
    if (mem_push) begin
      wreg_q[wr_ptr] <= Mem_wreg;
      data_q[wr_ptr] <= Mem_data;
    end
    if (alu_push) begin
      wreg_q[alu_slot] <= Alu_wreg;
      data_q[alu_slot] <= Alu_data;
    end
  end

  // Head write port, level and busy scoreboard.
  always_comb begin
    Write_enable = pop;
    Level        = count;
    if (pop) begin
      Wreg    = wreg_q[rd_ptr];
      Data_in = data_q[rd_ptr];
    end else begin
      Wreg    = 3'd0;
      Data_in = 16'd0;
    end
    Busy = 8'd0;
    for (int k = 0; k < DEPTH; k++) begin
      Busy = Busy | ((3'(k) < count) ? (8'd1 << wreg_q[rd_ptr + PTR_W'(k)]) : 8'd0);
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    Fwd_R1 = Rf_R1;
    Fwd_R2 = Rf_R2;
    for (int k = 0; k < DEPTH; k++) begin
      Fwd_R1 = ((3'(k) < count) && (wreg_q[rd_ptr + PTR_W'(k)] == Rreg1)) ?
               data_q[rd_ptr + PTR_W'(k)] : Fwd_R1;
      Fwd_R2 = ((3'(k) < count) && (wreg_q[rd_ptr + PTR_W'(k)] == Rreg2)) ?
               data_q[rd_ptr + PTR_W'(k)] : Fwd_R2;
    end
  end
`else
  logic unused_rreg;

  assign Fwd_R1      = Rf_R1;
  assign Fwd_R2      = Rf_R2;
  assign unused_rreg = ^{Rreg1, Rreg2};
`endif

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (fixed 4; only value supported).
REQ-002 SHALL have port Clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high; clears all state.
REQ-004 SHALL have ports Alu_valid input 1, Alu_wreg input 3, Alu_data input 16, Alu_ready output 1  ALU result producer.
REQ-005 SHALL have ports Mem_valid input 1, Mem_wreg input 3, Mem_data input 16, Mem_ready output 1  load result producer.
REQ-006 SHALL have ports Write_enable output 1, Wreg output 3, Data_in output 16  register-file write port.
REQ-007 SHALL have port Busy  output  8  bit k set when any queued entry targets register k.
REQ-008 SHALL have port Level  output  3  current entry count, 0..4.
REQ-009 SHALL have ports Rreg1 input 3, Rreg2 input 3, Rf_R1 input 16, Rf_R2 input 16, Fwd_R1 output 16, Fwd_R2 output 16  operand read path.

Function
REQ-010 SHALL store entries {wreg, data} in a 4-entry in-order FIFO with wrapping 2-bit read/write pointers and a 3-bit count.
REQ-011 SHALL enqueue a producer entry only on a rising edge where its valid and ready are both high; valid without ready is ignored, no state change.
REQ-012 SHALL compute ready combinationally from registered count only: Mem_ready = (count <= 3); Alu_ready = (count <= 2) or (count == 3 and not Mem_valid).
REQ-013 SHALL, when both producers enqueue in the same cycle, place the Mem entry ahead of the Alu entry.
REQ-014 SHALL drive Write_enable = (count != 0), with Wreg/Data_in taken combinationally from the head entry; Wreg/Data_in = 0 when empty.
REQ-015 SHALL pop the head on every rising edge where Write_enable is high (one write per cycle).
REQ-016 SHALL give one-cycle latency: entry accepted at edge N into an empty queue is written at edge N+1.
REQ-017 SHALL update count by (+enqueues − pop) each edge; simultaneous enqueue and pop at count 4 is impossible since ready is low; count never exceeds 4 nor underflows.
REQ-018 SHALL derive Busy combinationally as OR over valid entries of one-hot(wreg); duplicate targets keep the bit set until the last one pops.
REQ-019 SHALL drive Level = count.

Reset
REQ-020 SHALL on Reset clear count and pointers immediately, discarding queued entries with no register write.
REQ-021 SHALL hold, during and after Reset: Write_enable 0, Wreg 0, Data_in 0, Busy 0, Level 0, Alu_ready 1, Mem_ready 1.
REQ-022 SHALL not require clearing entry storage; contents of invalid entries SHALL never reach outputs.

Configuration
REQ-023 SHALL use macro WB_FORWARD_EN to compile operand forwarding in or out.
REQ-024 SHALL with WB_FORWARD_EN defined drive Fwd_R1 (Fwd_R2) with data of the youngest valid entry whose wreg equals Rreg1 (Rreg2), else Rf_R1 (Rf_R2); combinational.
REQ-025 SHALL without WB_FORWARD_EN drive Fwd_R1 = Rf_R1 and Fwd_R2 = Rf_R2 unconditionally; Busy still present.

Verification
REQ-026 SHALL cover: empty queue, Alu_valid with wreg 3, data 0x1234 at edge N -> Write_enable=1, Wreg=3, Data_in=0x1234 during cycle N..N+1, Level returns 0 after N+1.
REQ-027 SHALL cover: both valid same edge, Mem wreg 1/0xAAAA, Alu wreg 2/0x5555 -> writes to R1 then R2 on consecutive edges; Busy=0x06 then 0x04 then 0x00.
REQ-028 SHALL cover: fill to 4 with writeback running and producers held valid -> Mem_ready=0 at Level 4, Alu_ready=0 at Level 3 with Mem_valid=1, no entry lost or duplicated over 20 cycles.
REQ-029 SHALL cover: WB_FORWARD_EN, queue holds wreg 5 = 0x0001 then wreg 5 = 0x0002, Rreg1=5, Rf_R1=0xFFFF -> Fwd_R1=0x0002; undefined -> Fwd_R1=0xFFFF.
REQ-030 SHALL cover: Reset asserted mid-cycle with Level 3 -> outputs per REQ-021 immediately, no Write_enable pulse, next accepted entry written normally.
